// File: rtl/sipo_framer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sipo_framer
//
// Serial-in / parallel-out word framer. Bits arrive MSB-first on din and are
// consumed only on edges where en=1. The framer hunts for the SYNC word at
// every bit position. Once it finds SYNC it locks and delivers PAYLOAD data
// words, then checks the next word against SYNC. A bad sync is tolerated
// (flywheel) until MISS_MAX consecutive misses occur, at which point lock is
// dropped and hunting resumes.
//
// Parameters
//   WIDTH    bits per word (>= 2)
//   SYNC     frame sync word
//   PAYLOAD  data words per frame (1..255)
//   MISS_MAX consecutive sync misses before lock loss (1..15)
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   din        serial data bit, MSB-first
//   en         din qualifier; a bit is consumed only when en=1
//   dout       last assembled payload word (held until the next dout_valid)
//   dout_valid one-cycle strobe: dout has just been updated
//   locked     frame alignment held (state DATA or CHECK)
//   sync_err   one-cycle strobe: expected sync word did not match
// ---------------------------------------------------------------------------
module sipo_framer #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] SYNC    = 8'hA5,
    parameter int              PAYLOAD  = 4,
    parameter int              MISS_MAX = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int              BCW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0]  BIT_LAST   = BCW'(WIDTH - 1);
    localparam logic [7:0]      WORD_LAST  = 8'(PAYLOAD - 1);
    localparam logic [3:0]      MISS_LIMIT = 4'(MISS_MAX);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [BCW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [7:0]       word_cnt_reg, word_cnt_next;
    logic [3:0]       miss_cnt_reg, miss_cnt_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             dout_valid_reg, dout_valid_next;
    logic             sync_err_reg, sync_err_next;
    logic             locked_reg, locked_next;

    // The word as it will look after shifting in the current bit. All
    // decisions are made on this value so results appear right after the
    // edge that consumes the deciding bit.
    logic [WIDTH-1:0] word;
    assign word = {sr_reg[WIDTH-2:0], din};

    // Bitwise sync comparison.
    logic [WIDTH-1:0] bit_match;
    logic             sync_hit;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_match
        assign bit_match[gi] = word[gi] ~^ SYNC[gi];
    end

    assign sync_hit = &bit_match;

    logic       bit_last;
    logic       word_last;
    logic [3:0] miss_inc;
    logic       miss_out;

    assign bit_last  = (bit_cnt_reg == BIT_LAST);
    assign word_last = (word_cnt_reg == WORD_LAST);
    assign miss_inc  = miss_cnt_reg + 4'd1;
    assign miss_out  = (miss_inc == MISS_LIMIT);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= HUNT;
            sr_reg         <= '0;
            bit_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
            miss_cnt_reg   <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
            locked_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sr_reg         <= sr_next;
            bit_cnt_reg    <= bit_cnt_next;
            word_cnt_reg   <= word_cnt_next;
            miss_cnt_reg   <= miss_cnt_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            sync_err_reg   <= sync_err_next;
            locked_reg     <= locked_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (en) begin
            case (state_reg)
                HUNT: begin
                    if (sync_hit) state_next = DATA;
                end
                DATA: begin
                    if (bit_last && word_last) state_next = CHECK;
                end
                CHECK: begin
                    // A miss only drops lock once the miss budget is spent.
                    if (bit_last) state_next = (sync_hit || !miss_out) ? DATA : HUNT;
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output and datapath next-value logic
    // -----------------------------------------------------------------------
    always_comb begin
        sr_next         = sr_reg;
        bit_cnt_next    = bit_cnt_reg;
        word_cnt_next   = word_cnt_reg;
        miss_cnt_next   = miss_cnt_reg;
        dout_next       = dout_reg;
        // Strobes drop after one cycle whether or not a bit is consumed.
        dout_valid_next = 1'b0;
        sync_err_next   = 1'b0;
        // state_next equals state_reg when en=0, so lock is held on stalls.
        locked_next     = (state_next != HUNT);

        if (en) begin
            // sr is never cleared on lock loss: a sync word straddling the
            // loss point stays detectable in HUNT.
            sr_next = word;
            case (state_reg)
                HUNT: begin
                    if (sync_hit) begin
                        bit_cnt_next  = '0;
                        word_cnt_next = '0;
                        miss_cnt_next = '0;
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        bit_cnt_next    = '0;
                        dout_next       = word;
                        dout_valid_next = 1'b1;
                        word_cnt_next   = word_last ? 8'd0 : word_cnt_reg + 8'd1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
                CHECK: begin
                    if (bit_last) begin
                        bit_cnt_next  = '0;
                        word_cnt_next = '0;
                        if (sync_hit) begin
                            miss_cnt_next = '0;
                        end else begin
                            sync_err_next = 1'b1;
                            miss_cnt_next = miss_out ? 4'd0 : miss_inc;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    bit_cnt_next  = '0;
                    word_cnt_next = '0;
                    miss_cnt_next = '0;
                end
            endcase
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign locked     = locked_reg;
    assign sync_err   = sync_err_reg;

endmodule
